genbus_arb: RTL

- Arbitrates between NREQ bus requesters (CPU data port, DMA, debug) for the single shared genbus master port that feeds the peripheral slaves.
- Uses round-robin arbitration and latches each winning request, then drives one bus access at a time.
- Stretches an access while the addressed slave holds wait-state `ws`.
- Aborts with an error if `ws` is held for longer than a timeout.
- Sits between the requesters and the genbus master-side connection.

---
 rtl/genbus_pkg.sv | 24 ++
 rtl/genbus_rr_pick.sv | 32 +++
 rtl/genbus_arb.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/genbus_pkg.sv
// Shared types and constants for the genbus requester arbiter.
package genbus_pkg;

  localparam int GENBUS_AW = 16;
  localparam int GENBUS_DW = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } genbus_arb_state_t;

  typedef struct packed {
    logic [GENBUS_AW-1:0] adr;
    logic [GENBUS_DW-1:0] mdata;
    logic [1:0]           we;
    logic [1:0]           re;
  } genbus_req_t;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int genbus_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/genbus_rr_pick.sv
// Combinational round-robin picker: first requesting index above last_i, wrapping.
module genbus_rr_pick
  import genbus_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]               req_i,
  input  logic [genbus_idx_w(NREQ)-1:0] last_i,
  output logic                          valid_o,
  output logic [genbus_idx_w(NREQ)-1:0] idx_o
);

  localparam int IW = genbus_idx_w(NREQ);

  // Scan candidates from farthest to nearest so the nearest requester after last_i wins.
  always_comb begin
    int cand;
    cand    = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last_i) + k) % NREQ;
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IW'(cand);
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/genbus_arb.sv
// Round-robin arbiter driving one genbus access at a time, with wait-state
// stretching and an optional wait-state timeout that ends the access with an error.
module genbus_arb
  import genbus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = GENBUS_AW,
  parameter int DW      = GENBUS_DW,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_adr,
  input  logic [NREQ*DW-1:0] req_mdata,
  input  logic [NREQ*2-1:0] req_we,
  input  logic [NREQ*2-1:0] req_re,
  output logic [NREQ-1:0]   req_ack,
  output logic              req_err,
  output logic [DW-1:0]     req_sdata,
  output logic [AW-1:0]     bus_adr,
  output logic [DW-1:0]     bus_mdata,
  output logic [1:0]        bus_we,
  output logic [1:0]        bus_re,
  input  logic [DW-1:0]     bus_sdata,
  input  logic              bus_ws,
  output logic              busy
);

  localparam int IW  = genbus_idx_w(NREQ);
  localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TO_VAL   = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] WC_MAX   = {WCW{1'b1}};
  localparam logic [IW-1:0]  LAST_RST = IW'(NREQ - 1);

  genbus_arb_state_t state_q;
  logic [AW-1:0]     bus_adr_q;
  logic [DW-1:0]     bus_mdata_q;
  logic [1:0]        bus_we_q;
  logic [1:0]        bus_re_q;
  logic [WCW-1:0]    wait_cnt_q;
  logic [IW-1:0]     last_grant_q;
  logic [IW-1:0]     gnt_idx_q;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              timeout_hit;
  logic              xfer_done;
  logic [NREQ-1:0]   ack_vec;
  logic              err_bit;
  logic [DW-1:0]     sdata_vec;

  genbus_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i   (req_valid),
    .last_i  (last_grant_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Decide whether the current access completes this cycle, normally or by timeout.
  always_comb begin
    timeout_hit = 1'b0;
    xfer_done   = 1'b0;
    ack_vec     = '0;
    err_bit     = 1'b0;
    sdata_vec   = '0;
    if (state_q == ACCESS) begin
      if (!bus_ws) begin
        xfer_done          = 1'b1;
        ack_vec[gnt_idx_q] = 1'b1;
        sdata_vec          = bus_sdata;
      end else if ((TIMEOUT != 0) && (wait_cnt_q == TO_VAL)) begin
        timeout_hit        = 1'b1;
        xfer_done          = 1'b1;
        ack_vec[gnt_idx_q] = 1'b1;
        err_bit            = 1'b1;
      end else begin
        xfer_done = 1'b0;
      end
    end else begin
      xfer_done = 1'b0;
    end
  end

  // Arbiter FSM: grant and latch a request in IDLE, hold it on the bus until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_adr_q    <= '0;
      bus_mdata_q  <= '0;
      bus_we_q     <= 2'b00;
      bus_re_q     <= 2'b00;
      wait_cnt_q   <= '0;
      last_grant_q <= LAST_RST;
      gnt_idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            bus_adr_q    <= req_adr[int'(pick_idx)*AW +: AW];
            bus_mdata_q  <= req_mdata[int'(pick_idx)*DW +: DW];
            bus_we_q     <= req_we[int'(pick_idx)*2 +: 2];
            bus_re_q     <= req_re[int'(pick_idx)*2 +: 2];
            gnt_idx_q    <= pick_idx;
            last_grant_q <= pick_idx;
            wait_cnt_q   <= '0;
            state_q      <= ACCESS;
          end else begin
            bus_we_q <= 2'b00;
            bus_re_q <= 2'b00;
          end
        end
        ACCESS: begin
          if (xfer_done) begin
            bus_we_q   <= 2'b00;
            bus_re_q   <= 2'b00;
            wait_cnt_q <= '0;
            state_q    <= IDLE;
          end else if (wait_cnt_q != WC_MAX) begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end else begin
            wait_cnt_q <= wait_cnt_q;
          end
        end
        default: begin
          bus_we_q <= 2'b00;
          bus_re_q <= 2'b00;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus_adr   = bus_adr_q;
  assign bus_mdata = bus_mdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign busy      = (state_q == ACCESS);
  assign req_ack   = ack_vec;
  assign req_err   = err_bit;
  assign req_sdata = sdata_vec;

endmodule
